pe_filter_rx: RTL and testbench
===============================

# pe_filter_rx

Receive-side endpoint for filter packets delivered to a processing element (PE) column.
- Accepts 32-bit filter packets, decodes them and checks the destination address against its own address.
- Matching packets are written into a local row buffer of WIDTH_F weights; the complete row is handed to the PE datapath.
- Packets for other destinations are forwarded down the column (when forwarding is compiled in).
- Sits between the filter-memory packet source and the first PE of each column.

## Interface
Parameters:
- WIDTH_DATA, 13, bits per filter weight
- WIDTH_F, 5, weights per row (entries in row buffer)
- PE_ADDR, 8'h00, this node's destination address
- FILTER_TYPE, 2'b00, data_type value accepted as filter data

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_pkt  in  32  packet: [31] reserved (must be 0), [30:29] data_type, [28:21] dst_addr, [20:13] index, [12:0] data
- in_valid  in  1  in_pkt valid
- in_ready  out  1  block accepts in_pkt this cycle
- fwd_pkt  out  32  forwarded packet, bit-identical to the accepted input
- fwd_valid  out  1  fwd_pkt valid
- fwd_ready  in  1  downstream accepts fwd_pkt
- row_data  out  WIDTH_F*WIDTH_DATA  row buffer, entry k at [k*WIDTH_DATA +: WIDTH_DATA]
- row_valid  out  1  all WIDTH_F entries loaded
- row_take  in  1  PE consumes row; sampled only while row_valid=1
- drop_cnt  out  8  saturating count of discarded packets

## Operation
- Handshake: a transfer occurs on a rising edge where valid=1 and ready=1, on both the input and forward ports.
- Payload must be held stable while valid=1 and ready=0.
- FSM states:
  - LOAD (reset state): in_ready = !fwd_valid || fwd_ready.
  - FULL: in_ready = 0.
- Classification of an accepted packet, in priority order:
  1. in_pkt[31]=1, or data_type≠FILTER_TYPE: drop; drop_cnt += 1.
  2. dst_addr≠PE_ADDR: forward by loading the forward register; drop_cnt unchanged.
  3. index ≥ WIDTH_F: drop; drop_cnt += 1.
  4. Otherwise: write buf[index] = data and set loaded[index].
- Duplicate index: overwrites the entry and does not change loaded; completion requires every loaded bit set.
- LOAD→FULL: on the edge after which loaded is all ones; row_valid=1 in FULL only.
- FULL→LOAD: on an edge with row_take=1. On that edge loaded clears; buf contents are retained but stale.
- row_take while in LOAD: ignored.
- drop_cnt saturates at 8'hFF.
- Forward register: single entry. Loaded on accept; fwd_valid cleared on an edge with fwd_ready=1 and no new forward accept. Back-to-back forwarding runs at 1 packet/cycle when fwd_ready is held high.

## Timing
- Reset values: in_ready=0 during reset, fwd_valid=0, fwd_pkt=0, row_valid=0, row_data=0, drop_cnt=0, state=LOAD, loaded=0.
- First cycle after rst deasserts: in_ready=1.
- Write latency: a packet accepted at edge N is visible on row_data after edge N.
- Completion: if the last missing entry is accepted at edge N, row_valid=1 after edge N; the row completes in the same edge as the write.
- Forward latency: a packet accepted at edge N gives fwd_valid=1 with that payload after edge N.
- row_take at edge N: row_valid=0 and in_ready=1 after edge N. A packet waiting during FULL is accepted at edge N+1 at the earliest; the same-cycle release is not combinational.
- Reset mid-operation: all state returns to reset values on the edge; a partially loaded row and any pending forward packet are discarded, not delivered.
- fwd_ready low while fwd_valid=1: in_ready=0 even in LOAD, so matching packets also stall. Stream order is preserved.

## Configuration
- FILTER_RX_FWD_EN defined: forwarding as described above.
- FILTER_RX_FWD_EN undefined:
  - Forward register is removed; fwd_valid is tied 0 and fwd_pkt is tied 0.
  - dst_addr≠PE_ADDR packets are dropped and counted in drop_cnt.
  - in_ready = (state==LOAD); fwd_ready is ignored.

## Test plan
- Row load: send 5 packets with dst=PE_ADDR, index 0..4, data 13'h0011..13'h0015 → row_valid=1 after the 5th accept; row_data entries match. Pulse row_take → row_valid=0 and in_ready=1.
- Out-of-order and duplicates: indices 3,1,1,0,4,2 with distinct data → row_valid rises only after index 2; entry 1 holds the second write.
- Drops: packets with bit31=1, data_type=2'b01, and index=7 → drop_cnt=3, loaded unchanged. 300 bad packets → drop_cnt=8'hFF.
- Forwarding (FILTER_RX_FWD_EN): dst=8'h03 with fwd_ready=0 → fwd_valid=1 holding the packet and in_ready=0. Raise fwd_ready → packet delivered once; next input accepted the same edge.
- Backpressure in FULL: 6th matching packet is held with in_valid=1 → in_ready=0 until row_take; accepted at row_take edge+1.
- Reset mid-row: 3 entries loaded, then rst for 1 cycle → loaded=0 and row_valid=0. A following 5-packet load completes normally.

Source files
------------

// File: rtl/pe_filter_rx.sv
// Receive endpoint for filter packets: decodes, loads a WIDTH_F-entry weight row, forwards foreign packets.
// Optional forwarding path is compiled in with `define FILTER_RX_FWD_EN; otherwise foreign packets are dropped.
module pe_filter_rx #(
    parameter int unsigned WIDTH_DATA  = 13,
    parameter int unsigned WIDTH_F     = 5,
    parameter logic [7:0]  PE_ADDR     = 8'h00,
    parameter logic [1:0]  FILTER_TYPE = 2'b00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   in_pkt,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [31:0]                   fwd_pkt,
    output logic                          fwd_valid,
    input  logic                          fwd_ready,
    output logic [WIDTH_F*WIDTH_DATA-1:0] row_data,
    output logic                          row_valid,
    input  logic                          row_take,
    output logic [7:0]                    drop_cnt
);

    localparam int unsigned ROW_W = WIDTH_F * WIDTH_DATA;

    typedef enum logic {S_LOAD = 1'b0, S_FULL = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [WIDTH_F-1:0]   loaded_q, loaded_d;
    logic [7:0]           drop_q, drop_d;

    logic                  pkt_rsv;
    logic [1:0]            pkt_type;
    logic [7:0]            pkt_dst;
    logic [7:0]            pkt_idx;
    logic [WIDTH_DATA-1:0] pkt_data;
    logic                  accept;
    logic                  bad_hdr;
    logic                  addr_miss;
    logic                  idx_bad;
    logic                  wr_en;
    logic                  drop_inc;
    logic                  fwd_free;

    // Packet field decode and classification
    always_comb begin
        pkt_rsv   = in_pkt[31];
        pkt_type  = in_pkt[30:29];
        pkt_dst   = in_pkt[28:21];
        pkt_idx   = in_pkt[20:13];
        pkt_data  = WIDTH_DATA'(in_pkt[12:0]);
        accept    = in_valid && in_ready;
        bad_hdr   = pkt_rsv || (pkt_type != FILTER_TYPE);
        addr_miss = (pkt_dst != PE_ADDR);
        idx_bad   = (pkt_idx >= 8'(WIDTH_F));
        wr_en     = accept && !bad_hdr && !addr_miss && !idx_bad;
    end

`ifdef FILTER_RX_FWD_EN
    logic        fwd_valid_q, fwd_valid_d;
    logic [31:0] fwd_pkt_q, fwd_pkt_d;
    logic        fwd_acc;

    always_comb begin
        fwd_acc     = accept && !bad_hdr && addr_miss;
        drop_inc    = accept && (bad_hdr || (!addr_miss && idx_bad));
        fwd_free    = !fwd_valid_q || fwd_ready;
        fwd_valid_d = fwd_valid_q;
        fwd_pkt_d   = fwd_pkt_q;
        if (fwd_acc) begin
            fwd_valid_d = 1'b1;
            fwd_pkt_d   = in_pkt;
        end else if (fwd_ready) begin
            fwd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_pkt_q   <= 32'h0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_pkt_q   <= fwd_pkt_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_pkt   = fwd_pkt_q;
`else
    logic unused_fwd_ready;

    always_comb begin
        drop_inc = accept && (bad_hdr || addr_miss || idx_bad);
        fwd_free = 1'b1;
    end

    assign unused_fwd_ready = fwd_ready;
    assign fwd_valid        = 1'b0;
    assign fwd_pkt          = 32'h0;
`endif

    // Row buffer, loaded mask and saturating drop counter
    always_comb begin
        row_d    = row_q;
        loaded_d = loaded_q;
        drop_d   = drop_q;
        for (int unsigned k = 0; k < WIDTH_F; k++) begin
            if (wr_en && (pkt_idx == 8'(k))) begin
                row_d[k*WIDTH_DATA +: WIDTH_DATA] = pkt_data;
                loaded_d[k]                       = 1'b1;
            end
        end
        if ((state_q == S_FULL) && row_take) begin
            loaded_d = '0;
        end
        if (drop_inc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            loaded_q <= '0;
            drop_q   <= 8'h00;
        end else begin
            row_q    <= row_d;
            loaded_q <= loaded_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (&loaded_d) state_d = S_FULL;
            S_FULL:  if (row_take)  state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // Release after row_take comes from the registered state, never combinationally
    always_comb begin
        in_ready  = 1'b0;
        row_valid = 1'b0;
        case (state_q)
            S_LOAD:  in_ready  = !rst && fwd_free;
            S_FULL:  row_valid = 1'b1;
            default: ;
        endcase
    end

    assign row_data = row_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pe_filter_rx.sv
// Directed bench for pe_filter_rx: vector table for row loading and drops, hand sequences for corner cases.
module tb_pe_filter_rx;

    localparam int unsigned WD = 13;
    localparam int unsigned WF = 5;
`ifdef FILTER_RX_FWD_EN
    localparam logic [7:0] DD = 8'd0;
`else
    localparam logic [7:0] DD = 8'd1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       in_pkt;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       fwd_pkt;
    logic              fwd_valid;
    logic              fwd_ready;
    logic [WF*WD-1:0]  row_data;
    logic              row_valid;
    logic              row_take;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int errors = 0;
    int fwd_cnt = 0;

    pe_filter_rx dut (
        .clk       (clk),
        .rst       (rst),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fwd_pkt   (fwd_pkt),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_take  (row_take),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fwd_valid && fwd_ready) fwd_cnt <= fwd_cnt + 1;

    typedef struct {
        logic [31:0] pkt;
        logic        vld;
        logic        take;
        logic        exp_rv;
        logic        exp_rdy;
        logic [7:0]  exp_drop;
        int          eidx;
        logic [12:0] eval;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] mk(input logic rsv, input logic [1:0] typ,
                                       input logic [7:0] dst, input logic [7:0] idx,
                                       input logic [12:0] data);
        return {rsv, typ, dst, idx, data};
    endfunction

    function automatic logic [12:0] ent(input int k);
        return row_data[k*WD +: WD];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] p, input logic v, input logic t, input logic fr);
        in_pkt    = p;
        in_valid  = v;
        row_take  = t;
        fwd_ready = fr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] p, input logic v, input logic t, input logic rv,
                       input logic rdy, input logic [7:0] d, input int ei, input logic [12:0] ev);
        vec_t x;
        x.pkt = p; x.vld = v; x.take = t; x.exp_rv = rv; x.exp_rdy = rdy;
        x.exp_drop = d; x.eidx = ei; x.eval = ev;
        tv.push_back(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cnt;
        rst = 1'b1; in_pkt = 32'h0; in_valid = 1'b0; row_take = 1'b0; fwd_ready = 1'b1;

        // row load, hold in FULL, take
        add(mk(0,0,0,0,13'h0011), 1, 0, 0, 1, 8'd0, 0, 13'h0011);
        add(mk(0,0,0,1,13'h0012), 1, 0, 0, 1, 8'd0, 1, 13'h0012);
        add(mk(0,0,0,2,13'h0013), 1, 0, 0, 1, 8'd0, 2, 13'h0013);
        add(mk(0,0,0,3,13'h0014), 1, 0, 0, 1, 8'd0, 3, 13'h0014);
        add(mk(0,0,0,4,13'h0015), 1, 0, 1, 0, 8'd0, 4, 13'h0015);
        add(mk(0,0,0,0,13'h1FFF), 1, 0, 1, 0, 8'd0, 0, 13'h0011);
        add(32'h0,                0, 1, 0, 1, 8'd0, 0, 13'h0011);
        // out of order with duplicate index 1
        add(mk(0,0,0,3,13'h0103), 1, 0, 0, 1, 8'd0, 3, 13'h0103);
        add(mk(0,0,0,1,13'h0101), 1, 0, 0, 1, 8'd0, 1, 13'h0101);
        add(mk(0,0,0,1,13'h00AA), 1, 0, 0, 1, 8'd0, 1, 13'h00AA);
        add(mk(0,0,0,0,13'h0100), 1, 0, 0, 1, 8'd0, 0, 13'h0100);
        add(mk(0,0,0,4,13'h0104), 1, 0, 0, 1, 8'd0, 4, 13'h0104);
        add(mk(0,0,0,2,13'h0102), 1, 0, 1, 0, 8'd0, 2, 13'h0102);
        add(32'h0,                0, 0, 1, 0, 8'd0, 1, 13'h00AA);
        add(32'h0,                0, 1, 0, 1, 8'd0, 1, 13'h00AA);
        // drops in the middle of a partial row
        add(mk(0,0,0,0,13'h0200), 1, 0, 0, 1, 8'd0, 0, 13'h0200);
        add(mk(0,0,0,1,13'h0201), 1, 0, 0, 1, 8'd0, 1, 13'h0201);
        add(mk(0,0,0,2,13'h0202), 1, 0, 0, 1, 8'd0, 2, 13'h0202);
        add(mk(0,0,0,3,13'h0203), 1, 0, 0, 1, 8'd0, 3, 13'h0203);
        add(mk(1,0,0,4,13'h01EE), 1, 0, 0, 1, 8'd1, 4, 13'h0104);
        add(mk(0,1,0,4,13'h01AB), 1, 0, 0, 1, 8'd2, 4, 13'h0104);
        add(mk(0,0,0,7,13'h01CD), 1, 0, 0, 1, 8'd3, 4, 13'h0104);
        add(mk(0,0,0,5,13'h01CE), 1, 0, 0, 1, 8'd4, 4, 13'h0104);
        add(mk(0,0,3,4,13'h01CF), 1, 0, 0, 1, 8'd4 + DD, 4, 13'h0104);
        add(mk(0,0,0,4,13'h0204), 1, 0, 1, 0, 8'd4 + DD, 4, 13'h0204);
        add(32'h0,                0, 1, 0, 1, 8'd4 + DD, 4, 13'h0204);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_fwd_pkt", fwd_pkt, 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_row_data", 32'(row_data == '0), 32'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (tv[i]) begin
            cyc(tv[i].pkt, tv[i].vld, tv[i].take, 1'b1);
            chk($sformatf("v%0d_row_valid", i), 32'(row_valid), 32'(tv[i].exp_rv));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tv[i].exp_rdy));
            chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tv[i].exp_drop));
            chk($sformatf("v%0d_entry%0d", i, tv[i].eidx), 32'(ent(tv[i].eidx)), 32'(tv[i].eval));
        end

        // drop counter saturation
        for (int i = 0; i < 300; i++) cyc(mk(0,1,0,0,13'h0), 1, 0, 1);
        chk("drop_sat", 32'(drop_cnt), 32'hFF);
        chk("drop_sat_row_valid", 32'(row_valid), 32'd0);

        // packet held across row_take is accepted one edge later
        for (int k = 0; k < 5; k++) cyc(mk(0,0,0,8'(k),13'(13'h0300 + k)), 1, 0, 1);
        chk("bp_full", 32'(row_valid), 32'd1);
        cyc(mk(0,0,0,0,13'h0555), 1, 1, 1);
        chk("bp_take_rv", 32'(row_valid), 32'd0);
        chk("bp_take_rdy", 32'(in_ready), 32'd1);
        chk("bp_not_same_edge", 32'(ent(0)), 32'h0300);
        cyc(mk(0,0,0,0,13'h0555), 1, 0, 1);
        chk("bp_next_edge", 32'(ent(0)), 32'h0555);
        cyc(32'h0, 0, 0, 1);

`ifdef FILTER_RX_FWD_EN
        base_cnt = fwd_cnt;
        cyc(mk(0,0,8'h03,2,13'h0777), 1, 0, 0);
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_pkt", fwd_pkt, mk(0,0,8'h03,2,13'h0777));
        chk("fwd_stall_rdy", 32'(in_ready), 32'd0);
        cyc(mk(0,0,0,1,13'h00AB), 1, 0, 0);
        chk("fwd_hold_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_hold_entry1", 32'(ent(1)), 32'h0301);
        cyc(mk(0,0,0,1,13'h00AB), 1, 0, 1);
        chk("fwd_drained", 32'(fwd_valid), 32'd0);
        chk("fwd_same_edge_accept", 32'(ent(1)), 32'h00AB);
        chk("fwd_once", 32'(fwd_cnt - base_cnt), 32'd1);
        cyc(32'h0, 0, 0, 1);
`else
        base_cnt = 0;
        chk("nofwd_cnt", 32'(fwd_cnt - base_cnt), 32'd0);
        chk("nofwd_valid", 32'(fwd_valid), 32'd0);
`endif

        // reset mid-row discards the partial row
        for (int k = 0; k < 3; k++) cyc(mk(0,0,0,8'(k),13'(13'h0400 + k)), 1, 0, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_row_valid", 32'(row_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_row_data", 32'(row_data == '0), 32'd1);
        chk("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
        cyc(mk(0,0,0,3,13'h0503), 1, 0, 1);
        cyc(mk(0,0,0,4,13'h0504), 1, 0, 1);
        chk("mid_rst_loaded_cleared", 32'(row_valid), 32'd0);
        for (int k = 0; k < 3; k++) cyc(mk(0,0,0,8'(k),13'(13'h0500 + k)), 1, 0, 1);
        chk("reload_rv", 32'(row_valid), 32'd1);
        chk("reload_e0", 32'(ent(0)), 32'h0500);
        chk("reload_e4", 32'(ent(4)), 32'h0504);
        cyc(32'h0, 0, 1, 1);
        chk("reload_take", 32'(row_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
